// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer / arbiter block.
//   ARB_RR / ARB_FIXED : arbitration mode encodings for stream_mux_arb.ARB_MODE
//   state_t            : packet-lock FSM states
//   wrap_add           : modular index addition used for round-robin rotation
package stream_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // (a + b) mod n for small non-negative channel indices.
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel picker.
//   mode   : 0 = round-robin starting at rr_ptr, 1 = fixed priority (index 0 first)
//   rr_ptr : first index searched in round-robin mode
//   req    : per-channel request vector
//   winner : selected channel index (0 when nothing requested)
//   found  : 1 when any request is present
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             mode,
    input  logic [SEL_W-1:0] rr_ptr,
    input  logic [N_CH-1:0]  req,
    output logic [SEL_W-1:0] winner,
    output logic             found
);

    int base;
    int idx;

    // Both modes are the same rotating search; fixed priority simply starts at 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        base   = mode ? 0 : int'(rr_ptr);
        for (int i = 0; i < N_CH; i++) begin
            idx = wrap_add(base, i, N_CH);
            if (!found && req[idx[SEL_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel packet multiplexer with registered output.
// A channel is granted in IDLE and stays locked until its in_last beat is
// accepted; at least one IDLE cycle separates consecutive packets.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both 1. Valid never depends on ready; the output register holds
// out_data/out_last/out_ch stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      per-channel beat valid
//   in_data       channel i at [i*DATA_W +: DATA_W]
//   in_last       per-channel end-of-packet
//   in_ready      per-channel ready (only the granted channel, only in LOCKED)
//   sel_en, sel   manual channel select, sampled only in IDLE
//   out_valid/out_data/out_last/out_ch  registered output beat
//   out_ready     sink ready
//   state_dbg     current FSM state (0 = IDLE, 1 = LOCKED)
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = ARB_RR,
    localparam int SEL_W   = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     sel_en,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic                     state_dbg
);

    state_t             state;
    state_t             state_n;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   rr_ptr;

    logic [SEL_W-1:0]   arb_winner;
    logic               arb_found;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;
    logic               accept;

    // in_valid padded to the full sel range so an out-of-range manual
    // select simply reads a zero request.
    logic [(1<<SEL_W)-1:0] valid_ext;

    logic [DATA_W-1:0]  ch_data [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_split
        assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .mode   (ARB_MODE == ARB_FIXED),
        .rr_ptr (rr_ptr),
        .req    (in_valid),
        .winner (arb_winner),
        .found  (arb_found)
    );

    always_comb begin
        valid_ext             = '0;
        valid_ext[N_CH-1:0]   = in_valid;
        if (sel_en) begin
            win_idx   = sel;
            win_found = valid_ext[sel];
        end else begin
            win_idx   = arb_winner;
            win_found = arb_found;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n  = state;
        in_ready = '0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = LOCKED;
                end
            end
            LOCKED: begin
                // The out register can take a beat if empty or draining this edge.
                in_ready[grant] = !out_valid || out_ready;
                accept          = in_valid[grant] && in_ready[grant];
                if (accept && in_last[grant]) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && win_found) begin
                grant <= win_idx;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant];
                out_last  <= in_last[grant];
                out_ch    <= grant;
                if (in_last[grant]) begin
                    rr_ptr <= SEL_W'(wrap_add(int'(grant), 1, N_CH));
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_stream_mux_arb.sv
module tb_stream_mux_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic        sel_en;
  logic [1:0]  sel;
  logic        out_ready;
  logic        tsel;  // 0: round-robin DUT, 1: fixed-priority DUT

  logic [3:0]  in_valid_rr, in_valid_fp, in_ready_rr, in_ready_fp, cur_ready;
  logic        out_valid_rr, out_last_rr, state_rr;
  logic        out_valid_fp, out_last_fp, state_fp;
  logic [7:0]  out_data_rr, out_data_fp;
  logic [1:0]  out_ch_rr, out_ch_fp;

  logic [4:0]  in_valid5, in_ready5;
  logic [2:0]  sel5, out_ch5;
  logic        out_valid5, out_last5, state5;
  logic [7:0]  out_data5;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];  // {ch, last, data}
  logic [8:0]  src_mem[4][16];
  int          src_head[4];
  int          src_cnt[4];

  assign in_valid_rr = (tsel == 1'b0) ? in_valid : 4'b0;
  assign in_valid_fp = (tsel == 1'b1) ? in_valid : 4'b0;
  assign cur_ready   = tsel ? in_ready_fp : in_ready_rr;

  stream_mux_arb #(.N_CH(4), .DATA_W(8), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid_rr), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_rr), .sel_en(sel_en), .sel(sel), .out_valid(out_valid_rr),
    .out_data(out_data_rr), .out_last(out_last_rr), .out_ch(out_ch_rr),
    .out_ready(out_ready), .state_dbg(state_rr)
  );

  stream_mux_arb #(.N_CH(4), .DATA_W(8), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid_fp), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_fp), .sel_en(sel_en), .sel(sel), .out_valid(out_valid_fp),
    .out_data(out_data_fp), .out_last(out_last_fp), .out_ch(out_ch_fp),
    .out_ready(out_ready), .state_dbg(state_fp)
  );

  stream_mux_arb #(.N_CH(5), .DATA_W(8), .ARB_MODE(0)) dut_n5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_data(40'h44_33_22_11_00),
    .in_last(5'h1f), .in_ready(in_ready5), .sel_en(sel_en), .sel(sel5),
    .out_valid(out_valid5), .out_data(out_data5), .out_last(out_last5),
    .out_ch(out_ch5), .out_ready(out_ready), .state_dbg(state5)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each beat taken by the sink with the queue head.
  always @(negedge clk) begin
    logic        ov;
    logic [10:0] ow;
    ov = tsel ? out_valid_fp : out_valid_rr;
    ow = tsel ? {out_ch_fp, out_last_fp, out_data_fp} : {out_ch_rr, out_last_rr, out_data_rr};
    if (ov && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_beat: observed %0h expected none", ow);
      end else begin
        check("out_beat", {21'b0, ow}, {21'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      if (src_cnt[c] > 0) begin
        in_valid[c]        = 1'b1;
        in_last[c]         = src_mem[c][src_head[c]][8];
        in_data[c*8 +: 8]  = src_mem[c][src_head[c]][7:0];
      end else begin
        in_valid[c]        = 1'b0;
        in_last[c]         = 1'b0;
        in_data[c*8 +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic flush();
    for (int c = 0; c < 4; c++) begin
      src_head[c] = 0;
      src_cnt[c]  = 0;
    end
    drive();
  endtask

  task automatic push_pkt(input int ch, input int len, input logic [7:0] base, input bit expect_out);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      logic       l;
      d = base + 8'(i);
      l = (i == len - 1);
      src_mem[ch][src_head[ch] + src_cnt[ch]] = {l, d};
      src_cnt[ch]++;
      if (expect_out) exp_q.push_back({2'(ch), l, d});
    end
    drive();
  endtask

  // One clock: beats accepted at the coming edge are retired from the sources.
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    acc = in_valid & cur_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (acc[c] && src_cnt[c] > 0) begin
        src_head[c]++;
        src_cnt[c]--;
      end
    end
    drive();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    tick();
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst = 1'b1; tsel = 1'b0; sel_en = 1'b0; sel = 2'd0; out_ready = 1'b1;
    in_valid5 = 5'b0; sel5 = 3'd0;
    in_valid = '0; in_data = '0; in_last = '0;
    flush();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_rr, 0);
    check("rst_out_data", out_data_rr, 0);
    check("rst_out_last", out_last_rr, 0);
    check("rst_out_ch", out_ch_rr, 0);
    check("rst_in_ready", in_ready_rr, 0);
    check("rst_state", state_rr, 0);
    check("rst_fp_out_valid", out_valid_fp, 0);
    rst = 1'b0;
    tick();

    // 1: round-robin, ch0 and ch2 each with two 3-beat packets
    push_pkt(0, 3, 8'h10, 1);
    push_pkt(2, 3, 8'h20, 1);
    push_pkt(0, 3, 8'h30, 1);
    push_pkt(2, 3, 8'h40, 1);
    wait_drain("rr_order_drained", 60);
    flush();

    // 2: fixed priority, ch1 and ch3 together
    tsel = 1'b1;
    tick();
    push_pkt(1, 3, 8'h51, 1);
    push_pkt(3, 3, 8'h73, 1);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      tick();
      if (src_cnt[1] != 0) check("fp_ch3_blocked", in_ready_fp[3], 0);
    end
    wait_drain("fp_drained", 5);
    flush();
    tsel = 1'b0;
    tick();

    // 3: manual select of ch2 with every channel valid
    sel_en = 1'b1;
    sel = 2'd2;
    push_pkt(0, 2, 8'h80, 0);
    push_pkt(1, 2, 8'h90, 0);
    push_pkt(3, 2, 8'hB0, 0);
    push_pkt(2, 2, 8'hA0, 1);
    wait_drain("sel_drained", 30);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sel_no_regrant_ready", in_ready_rr, 0);
      check("sel_no_regrant_valid", out_valid_rr, 0);
    end
    flush();

    // 3b: out-of-range manual select on a 5-channel instance
    in_valid5 = 5'h1f;
    sel5 = 3'd5;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("sel5_ready", in_ready5, 0);
      check("sel5_out_valid", out_valid5, 0);
    end
    sel5 = 3'd7;
    tick();
    tick();
    check("sel7_out_valid", out_valid5, 0);
    sel5 = 3'd4;
    tick();
    tick();
    check("sel4_out_valid", out_valid5, 1);
    check("sel4_out_ch", out_ch5, 4);
    check("sel4_out_data", out_data5, 8'h44);
    in_valid5 = 5'b0;
    sel_en = 1'b0;
    tick();
    tick();

    // 4: backpressure while 0xA5 sits in the output register
    push_pkt(1, 4, 8'h00, 0);
    src_mem[1][0] = {1'b0, 8'h11};
    src_mem[1][1] = {1'b0, 8'h22};
    src_mem[1][2] = {1'b0, 8'hA5};
    src_mem[1][3] = {1'b1, 8'h33};
    drive();
    exp_q.push_back({2'd1, 1'b0, 8'h11});
    exp_q.push_back({2'd1, 1'b0, 8'h22});
    exp_q.push_back({2'd1, 1'b0, 8'hA5});
    exp_q.push_back({2'd1, 1'b1, 8'h33});
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (out_valid_rr && out_data_rr == 8'hA5) found = 1;
    end
    out_ready = 1'b0;
    check("bp_a5_seen", 32'(found), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_data_stable", out_data_rr, 8'hA5);
      check("bp_valid_held", out_valid_rr, 1);
      check("bp_in_ready", in_ready_rr[1], 0);
    end
    out_ready = 1'b1;
    wait_drain("bp_drained", 20);
    flush();

    // 5: reset during beat 2 of a 4-beat ch2 packet
    push_pkt(2, 4, 8'hC0, 0);
    exp_q.push_back({2'd2, 1'b0, 8'hC0});
    for (int k = 0; k < 10 && src_head[2] < 1; k++) tick();
    check("rst_mid_beat1_taken", src_head[2], 1);
    rst = 1'b1;
    tick();
    check("rst_mid_out_valid", out_valid_rr, 0);
    check("rst_mid_in_ready", in_ready_rr, 0);
    check("rst_mid_state", state_rr, 0);
    rst = 1'b0;
    flush();
    check("rst_mid_beat1_seen", exp_q.size(), 0);
    push_pkt(0, 1, 8'hD0, 1);
    push_pkt(3, 1, 8'hD3, 1);
    wait_drain("rst_ptr_drained", 20);
    flush();

    // 6: single-beat packets on ch3 only
    push_pkt(3, 1, 8'hE1, 1);
    push_pkt(3, 1, 8'hE2, 1);
    push_pkt(3, 1, 8'hE3, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("single_beat_valid", out_valid_rr, 32'(k % 2 == 0));
    end
    wait_drain("single_drained", 10);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
